// File: rtl/ps2_host_tx_if.sv
// Command handshake between a client and the PS/2 host transmitter.
// The client offers a byte with txValid/txReady and watches busy/txDone/txError.
interface ps2_host_tx_if;
    logic [7:0] txByte;
    logic       txValid;
    logic       txReady;
    logic       busy;
    logic       txDone;
    logic       txError;

    modport master (
        output txByte, txValid,
        input  txReady, busy, txDone, txError
    );

    modport slave (
        input  txByte, txValid,
        output txReady, busy, txDone, txError
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, clocks one odd-parity command byte
// out under device clocking, then reports the device ACK (txDone) or a failure (txError).
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int START_TIMEOUT  = 375000,
    parameter int BIT_TIMEOUT    = 5000
) (
    input  logic         pixelClk,
    input  logic         reset,
    ps2_host_tx_if.slave txIf,
    input  logic         ps2ClkIn,
    input  logic         ps2DataIn,
    output logic         ps2ClkOe,
    output logic         ps2DataOe
);

    localparam int MAX_A    = (INHIBIT_CYCLES > BIT_TIMEOUT) ? INHIBIT_CYCLES : BIT_TIMEOUT;
    localparam int MAX_WAIT = (MAX_A > START_TIMEOUT) ? MAX_A : START_TIMEOUT;
    localparam int TW       = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, WAIT1, SHIFT, ACK, RELWAIT, DONE, ERR
    } stateType;

    stateType      state, stateNext;

    logic [1:0]    clkSync, dataSync;
    logic          clkPrev;
    logic          clkS, dataS, fallEdge;

    logic [7:0]    shiftByte, byteNext;
    logic          parityBit, parNext;
    logic [3:0]    bitCnt, bitCntNext, edgeNum;
    logic [2:0]    bitSel;
    logic [TW-1:0] timer, timerNext;

    logic          clkOeNext, dataOeNext;
    logic          busyReg, busyNext;
    logic          doneReg, errReg;

    // The pins are idle-high, so the synchronisers reset to 1 to avoid a phantom edge.
    always_ff @(posedge pixelClk or negedge reset) begin
        if (!reset) begin
            clkSync  <= 2'b11;
            dataSync <= 2'b11;
            clkPrev  <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            clkSync  <= {clkSync[0], ps2ClkIn};
            dataSync <= {dataSync[0], ps2DataIn};
            clkPrev  <= clkSync[1];
        end
    end

    assign clkS     = clkSync[1];
    assign dataS    = dataSync[1];
    assign fallEdge = clkPrev & ~clkS;

    assign edgeNum  = bitCnt + 4'd1;
    assign bitSel   = 3'(edgeNum - 4'd1);

    always_ff @(posedge pixelClk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shiftByte <= '0;
            parityBit <= 1'b0;
            bitCnt    <= '0;
            timer     <= '0;
            ps2ClkOe  <= 1'b0;
            ps2DataOe <= 1'b0;
            busyReg   <= 1'b0;
            doneReg   <= 1'b0;
            errReg    <= 1'b0;
        end else begin
            state     <= stateNext;
            shiftByte <= byteNext;
            parityBit <= parNext;
            bitCnt    <= bitCntNext;
            timer     <= timerNext;
            ps2ClkOe  <= clkOeNext;
            ps2DataOe <= dataOeNext;
            busyReg   <= busyNext;
            doneReg   <= (stateNext == DONE);
            errReg    <= (stateNext == ERR);
        end
    end

    always_comb begin
        // NOTE: every value is defaulted to hold first, so no path through the case infers a latch.
        stateNext  = state;
        byteNext   = shiftByte;
        parNext    = parityBit;
        bitCntNext = bitCnt;
        timerNext  = timer + TW'(1);
        clkOeNext  = ps2ClkOe;
        dataOeNext = ps2DataOe;
        busyNext   = busyReg;

        case (state)
            IDLE: begin
                if (txIf.txValid) begin
                    byteNext   = txIf.txByte;
                    parNext    = ~^txIf.txByte;
                    bitCntNext = '0;
                    busyNext   = 1'b1;
                    clkOeNext  = 1'b1;
                    stateNext  = INHIBIT;
                end
            end

            INHIBIT: begin
                if (timer == TW'(INHIBIT_CYCLES - 1)) begin
                    clkOeNext = 1'b0;
                    stateNext = WAIT1;
                end else if (timer == TW'(INHIBIT_CYCLES - 2)) begin
                    dataOeNext = 1'b1;
                end
            end

            WAIT1: begin
                if (fallEdge) begin
                    dataOeNext = ~shiftByte[0];
                    bitCntNext = 4'd1;
                    stateNext  = SHIFT;
                end else if (timer == TW'(START_TIMEOUT - 1)) begin
                    stateNext = ERR;
                end
            end

            SHIFT: begin
                if (fallEdge) begin
                    bitCntNext = edgeNum;
                    timerNext  = '0;
                    if (edgeNum <= 4'd8) begin
                        dataOeNext = ~shiftByte[bitSel];
                    end else if (edgeNum == 4'd9) begin
                        dataOeNext = ~parityBit;
                    end else begin
                        dataOeNext = 1'b0;
                        stateNext  = ACK;
                    end
                end else if (timer == TW'(BIT_TIMEOUT - 1)) begin
                    stateNext = ERR;
                end
            end

            ACK: begin
                if (fallEdge) begin
                    bitCntNext = edgeNum;
                    stateNext  = dataS ? ERR : RELWAIT;
                end else if (timer == TW'(BIT_TIMEOUT - 1)) begin
                    stateNext = ERR;
                end
            end

            RELWAIT: begin
                if (clkS && dataS) begin
                    stateNext = DONE;
                end else if (fallEdge) begin
                    timerNext = '0;
                end else if (timer == TW'(BIT_TIMEOUT - 1)) begin
                    stateNext = ERR;
                end
            end

            DONE: begin
                busyNext  = 1'b0;
                stateNext = IDLE;
            end

            ERR: begin
                busyNext  = 1'b0;
                stateNext = IDLE;
            end

            default: begin
                stateNext = IDLE;
            end
        endcase

        // Any abort lets both lines float back to the pull-ups before the error pulse.
        if (stateNext == ERR) begin
            clkOeNext  = 1'b0;
            dataOeNext = 1'b0;
        end

        if (stateNext != state) begin
            timerNext = '0;
        end
    end

    assign txIf.txReady = (state == IDLE);
    assign txIf.busy    = busyReg;
    assign txIf.txDone  = doneReg;
    assign txIf.txError = errReg;

    // Completion pulses are mutually exclusive and the clock is only pulled during inhibit.
    assert property (@(posedge pixelClk) disable iff (!reset) !(doneReg && errReg));
    assert property (@(posedge pixelClk) disable iff (!reset) ps2ClkOe |-> (state == INHIBIT));

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the host while a
// scoreboard monitor matches each txDone/txError pulse against the expected outcome.
module tb_ps2_host_tx;

    localparam int INH = 40;
    localparam int STO = 500;
    localparam int BTO = 150;

    logic pixelClk = 1'b0;
    logic reset    = 1'b0;
    logic devClkLow  = 1'b0;
    logic devDataLow = 1'b0;
    logic ps2ClkOe, ps2DataOe;

    wire ps2ClkLine  = !(ps2ClkOe || devClkLow);
    wire ps2DataLine = !(ps2DataOe || devDataLow);

    ps2_host_tx_if txIf ();

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .START_TIMEOUT  (STO),
        .BIT_TIMEOUT    (BTO)
    ) dut (
        .pixelClk  (pixelClk),
        .reset     (reset),
        .txIf      (txIf),
        .ps2ClkIn  (ps2ClkLine),
        .ps2DataIn (ps2DataLine),
        .ps2ClkOe  (ps2ClkOe),
        .ps2DataOe (ps2DataOe)
    );

    always #5 pixelClk = ~pixelClk;

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;
    int pulseCount  = 0;
    int pulseCycle  = 0;
    int lastFall    = 0;
    bit expQ[$];
    bit expPop;

    always @(posedge pixelClk) cycle++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic checkRange(input string name, input int act, input int lo, input int hi);
        vectors++;
        if (act < lo || act > hi) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge pixelClk);
            #1;
        end
    endtask

    // Scoreboard monitor: each completion pulse must match the oldest queued outcome.
    always @(negedge pixelClk) begin
        if (reset && (txIf.txDone || txIf.txError)) begin
            pulseCount++;
            pulseCycle = cycle;
            check("pulse exclusive", txIf.txDone & txIf.txError, 0);
            check("lines released at pulse", {ps2ClkOe, ps2DataOe}, 0);
            check("busy during pulse", txIf.busy, 1);
            check("pulse was expected", expQ.size() != 0, 1);
            if (expQ.size() != 0) begin
                expPop = expQ.pop_front();
                check("outcome is txDone", txIf.txDone, expPop);
            end
        end
    end

    task automatic waitReady();
        int budget = 0;
        while (!txIf.txReady && budget < 50) begin
            tick(1);
            budget++;
        end
        check("txReady before send", txIf.txReady, 1);
    endtask

    // One host transaction against a device that gives nEdges falling edges.
    task automatic sendByte(input logic [7:0] b, input int nEdges, input bit ack, input int half);
        int inhibitLen = 0;
        int dataLow    = 0;
        int relCycle;
        int budget;
        int startPulses;
        int k;
        bit busyDrop = 1'b0;
        logic [9:0] frame = '0;
        logic [9:0] expFrame;
        logic [9:0] mask;

        expFrame = {1'b1, ($countones(b) % 2 == 0), b};
        expQ.push_back(nEdges == 11 && ack);
        startPulses = pulseCount;

        waitReady();
        txIf.txByte  = b;
        txIf.txValid = 1'b1;
        tick(1);
        check("busy after accept", txIf.busy, 1);
        txIf.txByte = ~b;
        while (ps2ClkOe && inhibitLen < INH + 20) begin
            inhibitLen++;
            dataLow += int'(ps2DataOe);
            tick(1);
            txIf.txValid = 1'b0;
        end
        txIf.txValid = 1'b0;
        check("inhibit length", inhibitLen, INH);
        check("data pulled in last inhibit cycle only", dataLow, 1);
        relCycle = cycle;
        check("start bit on line", ps2DataLine, 0);

        for (int i = 1; i <= nEdges; i++) begin
            tick(half);
            if (i == 11 && ack) begin
                devDataLow = 1'b1;
                tick(2);
            end
            devClkLow = 1'b1;
            lastFall  = cycle;
            if (!txIf.busy) busyDrop = 1'b1;
            tick(half);
            if (i <= 10) frame[i-1] = ps2DataLine;
            devClkLow = 1'b0;
        end
        if (nEdges == 11 && ack) begin
            tick(3);
            devDataLow = 1'b0;
        end

        budget = 0;
        while (pulseCount == startPulses && budget < STO + BTO + 200) begin
            tick(1);
            budget++;
        end
        check("outcome pulse seen", pulseCount - startPulses, 1);
        tick(5);
        check("single pulse per byte", pulseCount - startPulses, 1);
        check("busy held through frame", busyDrop, 0);
        check("busy cleared after pulse", txIf.busy, 0);

        k = (nEdges > 10) ? 10 : nEdges;
        mask = 10'((1 << k) - 1);
        if (k > 0) check("frame bits", frame & mask, expFrame & mask);
        if (nEdges == 0) checkRange("start timeout", pulseCycle - relCycle, STO - 2, STO + 2);
        else if (nEdges < 10) checkRange("bit timeout", pulseCycle - lastFall, BTO, BTO + 5);
    endtask

    initial begin
        int startPulses;
        int budget;
        logic [7:0] rb;
        bit rAck;
        int rHalf;

        txIf.txByte  = '0;
        txIf.txValid = 1'b0;
        tick(3);
        check("reset ps2ClkOe", ps2ClkOe, 0);
        check("reset ps2DataOe", ps2DataOe, 0);
        check("reset txReady", txIf.txReady, 1);
        check("reset busy", txIf.busy, 0);
        check("reset txDone", txIf.txDone, 0);
        check("reset txError", txIf.txError, 0);
        reset = 1'b1;
        tick(2);

        sendByte(8'hED, 11, 1'b1, 20);
        sendByte(8'h01, 11, 1'b1, 15);
        sendByte(8'hA5, 0, 1'b1, 20);
        sendByte(8'h3C, 5, 1'b1, 20);
        sendByte(8'h96, 11, 1'b0, 20);

        repeat (6) begin
            rb    = 8'($urandom);
            rAck  = ($urandom_range(0, 4) != 0);
            rHalf = int'($urandom_range(6, 30));
            sendByte(rb, 11, rAck, rHalf);
        end

        // Abort in the middle of the data bits: no pulse, lines released at once.
        waitReady();
        txIf.txByte  = 8'h52;
        txIf.txValid = 1'b1;
        tick(1);
        txIf.txValid = 1'b0;
        budget = 0;
        while (ps2ClkOe && budget < INH + 20) begin
            tick(1);
            budget++;
        end
        for (int i = 1; i <= 4; i++) begin
            tick(15);
            devClkLow = 1'b1;
            tick(15);
            devClkLow = 1'b0;
        end
        tick(10);
        check("data driven in shift", ps2DataOe, 1);
        check("busy in shift", txIf.busy, 1);
        startPulses = pulseCount;
        @(negedge pixelClk);
        reset = 1'b0;
        #1;
        check("abort ps2ClkOe", ps2ClkOe, 0);
        check("abort ps2DataOe", ps2DataOe, 0);
        check("abort txReady", txIf.txReady, 1);
        check("abort busy", txIf.busy, 0);
        check("abort pulses", {txIf.txDone, txIf.txError}, 0);
        tick(3);
        reset = 1'b1;
        tick(20);
        check("no pulse after abort", pulseCount - startPulses, 0);

        sendByte(8'hFF, 11, 1'b1, 20);

        check("scoreboard drained", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
